// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, stall encoding, ALU/operand indices and MD function codes for ex_stage
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 44;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // alu_op bit positions (one-hot, MSB first: add .. lui)
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // operand select bit positions
  localparam int SRC1_RDATA1 = 0;
  localparam int SRC1_PC     = 1;
  localparam int SRC1_SA     = 2;
  localparam int SRC2_RDATA2 = 0;
  localparam int SRC2_SEXT   = 1;
  localparam int SRC2_EIGHT  = 2;
  localparam int SRC2_ZEXT   = 3;

  // function field codes of the multiply/divide group (opcode 0)
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - 32-step restoring divider with signed/unsigned support
// Ports: clk, rst (sync, active-high); start (held while a divide occupies EX,
// dropping it in DONE releases the unit); signed_op; a dividend; b divisor;
// busy/done status; quot/rem sign-corrected results, valid while done.
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  div_state_e  state;
  logic [4:0]  cnt;
  logic [31:0] r_q, q_q, d_q;
  logic        neg_q, neg_r;

  logic [31:0] a_abs, b_abs, r_next;
  logic [32:0] shifted, diff;
  logic        ge;
  logic        unused_div;

  assign a_abs = (signed_op && a[31]) ? -a : a;
  assign b_abs = (signed_op && b[31]) ? -b : b;

  // One restoring step: shift the next dividend bit into the partial remainder.
  // A zero divisor always subtracts, giving q=all ones and r=dividend.
  always_comb begin
    shifted = {r_q, q_q[31]};
    diff    = shifted - {1'b0, d_q};
    ge      = (shifted >= {1'b0, d_q});
    r_next  = ge ? diff[31:0] : shifted[31:0];
  end

  assign unused_div = diff[32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          r_q   <= '0;
          q_q   <= a_abs;
          d_q   <= b_abs;
          neg_q <= signed_op & (a[31] ^ b[31]);
          neg_r <= signed_op & a[31];
          cnt   <= '0;
          state <= DIV_BUSY;
        end
        DIV_BUSY: begin
          r_q <= r_next;
          q_q <= {q_q[30:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DIV_DONE;
        end
        DIV_DONE: if (!start) state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);
  assign quot = neg_q ? -q_q : q_q;
  assign rem  = neg_r ? -r_q : r_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, HI/LO, multiplier, divider, SRAM request, forwarding
// Ports: clk, rst (sync, active-high); stall[5:0] per-stage stop flags;
// id_to_ex_bus from decode; ex_to_mem_bus to memory; ex_to_id_bus forwarding;
// data_sram_en/wen/addr/wdata memory request; stallreq_ex while divide pending.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_ex
);

  logic [ID_TO_EX_WD-1:0] id_r;

  // An all-zero register is a bubble: no write-back, no memory request.
  always_ff @(posedge clk) begin
    if (rst)                                      id_r <= '0;
    else if (stall[2] == STOP && stall[3] == NO_STOP) id_r <= '0;
    else if (stall[3] == NO_STOP)                 id_r <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  src1;
  logic [3:0]  src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, src1, src2, ram_en, ram_wen, rf_we, rf_waddr,
          sel_rf_res, rdata1, rdata2} = id_r;

  logic [31:0] opa, opb, alu_res;
  logic [4:0]  shamt;

  always_comb begin
    opa = '0;
    if (src1[SRC1_RDATA1]) opa = rdata1;
    if (src1[SRC1_PC])     opa = pc;
    if (src1[SRC1_SA])     opa = {27'b0, inst[10:6]};
    opb = '0;
    if (src2[SRC2_RDATA2]) opb = rdata2;
    if (src2[SRC2_SEXT])   opb = {{16{inst[15]}}, inst[15:0]};
    if (src2[SRC2_EIGHT])  opb = 32'd8;
    if (src2[SRC2_ZEXT])   opb = {16'b0, inst[15:0]};
  end

  assign shamt = opa[4:0];

  always_comb begin
    alu_res = '0;
    if (alu_op[ALU_ADD])  alu_res = opa + opb;
    if (alu_op[ALU_SUB])  alu_res = opa - opb;
    if (alu_op[ALU_SLT])  alu_res = {31'b0, $signed(opa) < $signed(opb)};
    if (alu_op[ALU_SLTU]) alu_res = {31'b0, opa < opb};
    if (alu_op[ALU_AND])  alu_res = opa & opb;
    if (alu_op[ALU_NOR])  alu_res = ~(opa | opb);
    if (alu_op[ALU_OR])   alu_res = opa | opb;
    if (alu_op[ALU_XOR])  alu_res = opa ^ opb;
    if (alu_op[ALU_SLL])  alu_res = opb << shamt;
    if (alu_op[ALU_SRL])  alu_res = opb >> shamt;
    if (alu_op[ALU_SRA])  alu_res = $signed(opb) >>> shamt;
    if (alu_op[ALU_LUI])  alu_res = {opb[15:0], 16'b0};
  end

  // Multiply/divide group decode
  logic md_grp, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
  assign md_grp   = (inst[31:26] == 6'd0);
  assign is_mfhi  = md_grp && inst[5:0] == FN_MFHI;
  assign is_mflo  = md_grp && inst[5:0] == FN_MFLO;
  assign is_mthi  = md_grp && inst[5:0] == FN_MTHI;
  assign is_mtlo  = md_grp && inst[5:0] == FN_MTLO;
  assign is_mult  = md_grp && inst[5:0] == FN_MULT;
  assign is_multu = md_grp && inst[5:0] == FN_MULTU;
  assign is_div   = md_grp && inst[5:0] == FN_DIV;
  assign is_divu  = md_grp && inst[5:0] == FN_DIVU;

  logic [31:0] hi, lo;
  logic [63:0] mul_a, mul_b, prod;

  // Sign- or zero-extend to 64 bits so one truncated product serves both forms.
  assign mul_a = is_mult ? {{32{rdata1[31]}}, rdata1} : {32'b0, rdata1};
  assign mul_b = is_mult ? {{32{rdata2[31]}}, rdata2} : {32'b0, rdata2};
  assign prod  = mul_a * mul_b;

  logic        div_in_ex, div_busy, div_done, div_start, leaving;
  logic [31:0] div_quot, div_rem;

  assign div_in_ex = is_div | is_divu;
  assign leaving   = (stall[3] == NO_STOP);
  // Held for the whole divide; it falls as the instruction leaves EX in DONE.
  assign div_start = div_in_ex & ~(div_done & leaving);

  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (is_div),
    .a         (rdata1),
    .b         (rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  assign stallreq_ex = div_in_ex & ~div_done;

  // HI/LO commit only as the instruction leaves EX, so the next mfhi/mflo
  // reads the new value directly from the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (leaving) begin
      if (div_in_ex && div_done) begin
        lo <= div_quot;
        hi <= div_rem;
      end else if (is_mult || is_multu) begin
        {hi, lo} <= prod;
      end else if (is_mthi) begin
        hi <= rdata1;
      end else if (is_mtlo) begin
        lo <= rdata1;
      end
    end
  end

  logic [31:0] result;
  logic        out_we;
  logic [4:0]  out_waddr;

  assign result    = is_mfhi ? hi : (is_mflo ? lo : alu_res);
  assign out_we    = rf_we | is_mfhi | is_mflo;
  assign out_waddr = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, out_we, out_waddr, result};
  assign ex_to_id_bus    = {out_we, out_waddr, result, inst[31:26]};
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  logic unused_ex;
  assign unused_ex = ^{stall[5:4], stall[1:0], inst[25:16], div_busy};

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_man;
  logic [158:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [43:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         stallreq_ex;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  // Stall controller stand-in: EX request stops stages 0..3.
  assign stall = stall_man | {2'b00, {4{stallreq_ex}}};

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_ex     (stallreq_ex)
  );

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic en,
                                      input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, en, wen, we, wa, sel, r1, r2};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [158:0] b);
    id_bus = b;
    @(posedge clk);
    #1;
    id_bus = '0;
  endtask

  task automatic count_stall();
    n = 0;
    while (stallreq_ex && n < 60) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [31:0] I_MFHI  = 32'h0000_1010;  // rd=2
  localparam logic [31:0] I_MFLO  = 32'h0000_1812;  // rd=3
  localparam logic [31:0] I_DIV   = 32'h0085_001A;
  localparam logic [31:0] I_DIVU  = 32'h0085_001B;
  localparam logic [31:0] I_MULTU = 32'h0085_0019;

  initial begin
    rst = 1'b1; stall_man = '0; id_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_bus", {12'b0, ex_to_mem_bus}, 64'd0);
    chk("rst_id_bus",  {20'b0, ex_to_id_bus}, 64'd0);
    chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_ex}, 64'd0);
    rst = 1'b0;

    step(mk(32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 32'h7FFF_FFFF, 32'h1));
    chk("addu_wrap", ex_to_mem_bus[31:0], 64'h8000_0000);

    step(mk(32'h0, 32'h0, 12'h200, 3'b001, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 32'hFFFF_FFFF, 32'h1));
    chk("slt", ex_to_mem_bus[31:0], 64'h1);
    step(mk(32'h0, 32'h0, 12'h100, 3'b001, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 32'hFFFF_FFFF, 32'h1));
    chk("sltu", ex_to_mem_bus[31:0], 64'h0);

    step(mk(32'h0, 32'h3C04_1234, 12'h001, 3'b000, 4'b1000, 0, 4'h0, 1, 5'd4, 0, 32'h0, 32'h0));
    chk("lui", ex_to_mem_bus[31:0], 64'h1234_0000);

    step(mk(32'h0, 32'h0000_0100, 12'h008, 3'b100, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 32'h0, 32'h0000_000F));
    chk("sll", ex_to_mem_bus[31:0], 64'h0000_00F0);

    step(mk(32'h0040_0000, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100, 0, 4'h0, 1, 5'd31, 0, 32'h0, 32'h0));
    chk("jal_result", ex_to_mem_bus[31:0], 64'h0040_0008);
    chk("jal_waddr", ex_to_mem_bus[37:32], {58'b0, 6'b1_11111});

    step(mk(32'h0, 32'hAC22_FFFC, 12'h800, 3'b001, 4'b0010, 1, 4'hF, 0, 5'd0, 0, 32'h1000_0000, 32'hDEAD_BEEF));
    chk("sw_addr", data_sram_addr, 64'h0FFF_FFFC);
    chk("sw_en_wen", {data_sram_en, data_sram_wen}, 64'h1F);
    chk("sw_wdata", data_sram_wdata, 64'hDEAD_BEEF);

    step(mk(32'h0, 32'h8C22_FFFC, 12'h800, 3'b001, 4'b0010, 1, 4'h0, 1, 5'd2, 1, 32'h1000_0000, 32'h0));
    chk("lw_addr", data_sram_addr, 64'h0FFF_FFFC);
    chk("lw_en_wen", {data_sram_en, data_sram_wen}, 64'h10);
    chk("lw_op", ex_to_id_bus[5:0], 64'h23);

    stall_man = 6'b000100;
    step(mk(32'h0, 32'h8C22_FFFC, 12'h800, 3'b001, 4'b0010, 1, 4'h0, 1, 5'd2, 1, 32'h1000_0000, 32'h0));
    chk("bubble_we_en", {ex_to_mem_bus[37], data_sram_en}, 64'h0);
    stall_man = '0;

    // div -7 / 2
    step(mk(32'h0, I_DIV, 12'h0, 3'b001, 4'b0001, 0, 4'h0, 0, 5'd0, 0, 32'hFFFF_FFF9, 32'h2));
    count_stall();
    chk("div_stall_cycles", n, 64'd33);
    step(mk(32'h0, I_MFHI, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd2, 0, 32'h0, 32'h0));
    chk("div_hi", ex_to_mem_bus[31:0], 64'hFFFF_FFFF);
    chk("mfhi_we", ex_to_mem_bus[37], 64'h1);
    step(mk(32'h0, I_MFLO, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd3, 0, 32'h0, 32'h0));
    chk("div_lo", ex_to_mem_bus[31:0], 64'hFFFF_FFFD);

    // divu 5 / 0
    step(mk(32'h0, I_DIVU, 12'h0, 3'b001, 4'b0001, 0, 4'h0, 0, 5'd0, 0, 32'h5, 32'h0));
    count_stall();
    chk("divu0_stall_cycles", n, 64'd33);
    step(mk(32'h0, I_MFLO, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd3, 0, 32'h0, 32'h0));
    chk("divu0_lo", ex_to_mem_bus[31:0], 64'hFFFF_FFFF);
    step(mk(32'h0, I_MFHI, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd2, 0, 32'h0, 32'h0));
    chk("divu0_hi", ex_to_mem_bus[31:0], 64'h5);

    // multu
    step(mk(32'h0, I_MULTU, 12'h0, 3'b001, 4'b0001, 0, 4'h0, 0, 5'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    chk("multu_no_stall", stallreq_ex, 64'h0);
    step(mk(32'h0, I_MFHI, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd2, 0, 32'h0, 32'h0));
    chk("multu_hi", ex_to_mem_bus[31:0], 64'hFFFF_FFFE);
    step(mk(32'h0, I_MFLO, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd3, 0, 32'h0, 32'h0));
    chk("multu_lo", ex_to_mem_bus[31:0], 64'h1);

    // reset part-way through a divide (counter at 10)
    step(mk(32'h0, I_DIV, 12'h0, 3'b001, 4'b0001, 0, 4'h0, 0, 5'd0, 0, 32'h64, 32'h3));
    repeat (11) @(posedge clk);
    #1;
    chk("mid_div_stalling", stallreq_ex, 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_div_stallreq", stallreq_ex, 64'h0);
    chk("rst_div_mem_bus", {12'b0, ex_to_mem_bus}, 64'd0);
    chk("rst_div_id_bus", {20'b0, ex_to_id_bus}, 64'd0);
    step(mk(32'h0, I_MFHI, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd2, 0, 32'h0, 32'h0));
    chk("rst_hi", ex_to_mem_bus[31:0], 64'h0);
    step(mk(32'h0, I_MFLO, 12'h0, 3'b0, 4'b0, 0, 4'h0, 1, 5'd3, 0, 32'h0, 32'h0));
    chk("rst_lo", ex_to_mem_bus[31:0], 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
